// File: rtl/int_inject_pkg.sv
// Shared types and constants for the interrupt injection controller.
package int_inject_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_DELAY  = 3'd2,
    ST_ASSERT = 3'd3,
    ST_REARM  = 3'd4
  } chan_state_e;

  localparam logic [31:0] ACK_STRIDE    = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hffff_fffc;

endpackage

// File: rtl/int_inject_ctrl_if.sv
// CPU-observation and configuration signals of the interrupt injection controller.
interface int_inject_ctrl_if #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned DELAY_W = 8
);
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [31:0]        macroscopic_pc;
  logic [31:0]        m_int_addr;
  logic [3:0]         m_int_byteen;
  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [31:0]        cfg_target_pc;
  logic [CNT_W-1:0]   cfg_count;
  logic [DELAY_W-1:0] cfg_delay;

  modport master (
    output macroscopic_pc, m_int_addr, m_int_byteen,
    output cfg_we, cfg_ch, cfg_target_pc, cfg_count, cfg_delay
  );

  modport slave (
    input macroscopic_pc, m_int_addr, m_int_byteen,
    input cfg_we, cfg_ch, cfg_target_pc, cfg_count, cfg_delay
  );
endinterface

// File: rtl/int_inject_chan.sv
// One interrupt channel: PC trigger, fire delay, repeat count and ack handling.
// INT_TIMEOUT_EN adds an auto-release counter and a sticky timeout flag.
module int_inject_chan
  import int_inject_pkg::*;
#(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned DELAY_W = 8
`ifdef INT_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 64
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc_aligned,
  input  logic               ack,
  input  logic               cfg_load,
  input  logic [31:0]        cfg_target_pc,
  input  logic [CNT_W-1:0]   cfg_count,
  input  logic [DELAY_W-1:0] cfg_delay,
  output logic               interrupt,
  output logic               timeout_flag
);

  chan_state_e        state_reg;
  logic [31:0]        target_reg;
  logic [CNT_W-1:0]   remaining_reg;
  logic [DELAY_W-1:0] delay_reg;
  logic [DELAY_W-1:0] dcnt_reg;
  logic               interrupt_reg;

  logic               match;
  logic               release_evt;
  logic [CNT_W-1:0]   remaining_next;

  assign match          = (pc_aligned == target_reg);
  assign remaining_next = (remaining_reg != '0) ? remaining_reg - CNT_W'(1) : '0;

`ifdef INT_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] tcnt_reg;
  logic            tflag_reg;
  logic            expire;

  // Ack wins over an expiry landing on the same edge.
  assign expire = (state_reg == ST_ASSERT) && !ack && (tcnt_reg == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || cfg_load) begin
      tcnt_reg  <= '0;
      tflag_reg <= 1'b0;
    end else if (state_reg != ST_ASSERT) begin
      tcnt_reg <= '0;
    end else if (expire) begin
      tcnt_reg  <= '0;
      tflag_reg <= 1'b1;
    end else begin
      tcnt_reg <= tcnt_reg + TO_W'(1);
    end
  end

  assign release_evt  = ack || expire;
  assign timeout_flag = tflag_reg;
`else
  assign release_evt  = ack;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      target_reg    <= '0;
      remaining_reg <= '0;
      delay_reg     <= '0;
      dcnt_reg      <= '0;
      interrupt_reg <= 1'b0;
    end else if (cfg_load) begin
      target_reg    <= cfg_target_pc;
      remaining_reg <= cfg_count;
      delay_reg     <= cfg_delay;
      dcnt_reg      <= '0;
      interrupt_reg <= 1'b0;
      state_reg     <= (cfg_count != '0) ? ST_ARMED : ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: ;
        ST_ARMED: begin
          if (match) begin
            if (delay_reg == '0) begin
              state_reg     <= ST_ASSERT;
              interrupt_reg <= 1'b1;
            end else begin
              state_reg <= ST_DELAY;
              dcnt_reg  <= delay_reg;
            end
          end
        end
        ST_DELAY: begin
          if (dcnt_reg <= DELAY_W'(1)) begin
            state_reg     <= ST_ASSERT;
            interrupt_reg <= 1'b1;
          end else begin
            dcnt_reg <= dcnt_reg - DELAY_W'(1);
          end
        end
        ST_ASSERT: begin
          if (release_evt) begin
            interrupt_reg <= 1'b0;
            remaining_reg <= remaining_next;
            state_reg     <= (remaining_next != '0) ? ST_REARM : ST_IDLE;
          end
        end
        // Hold off until the PC leaves the target so one visit fires once.
        ST_REARM: begin
          if (!match) state_reg <= ST_ARMED;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign interrupt = interrupt_reg;

endmodule

// File: rtl/int_inject_ctrl.sv
// Interrupt stimulus generator: NCH PC-triggered channels with store-based ack.
// Optional macro INT_TIMEOUT_EN enables per-channel auto-release after TIMEOUT cycles.
module int_inject_ctrl
  import int_inject_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned DELAY_W  = 8,
  parameter logic [31:0] ACK_BASE = 32'h0000_7f20
`ifdef INT_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 64
`endif
) (
  input  logic               clk,
  input  logic               reset,
  int_inject_ctrl_if.slave   bus,
  output logic [NCH-1:0]     interrupt,
  output logic               irq_any,
  output logic [NCH-1:0]     timeout_flag
);

  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [31:0] pc_aligned;
  logic [31:0] ack_addr_aligned;
  logic        store_valid;

  assign pc_aligned       = bus.macroscopic_pc & PC_ALIGN_MASK;
  assign ack_addr_aligned = bus.m_int_addr & PC_ALIGN_MASK;
  assign store_valid      = |bus.m_int_byteen;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      localparam logic [31:0] CH_ACK_ADDR = ACK_BASE + ACK_STRIDE * 32'(gi);

      logic ack;
      logic cfg_load;

      assign ack      = store_valid && (ack_addr_aligned == CH_ACK_ADDR);
      assign cfg_load = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));

      int_inject_chan #(
        .CNT_W   (CNT_W),
        .DELAY_W (DELAY_W)
`ifdef INT_TIMEOUT_EN
        , .TIMEOUT (TIMEOUT)
`endif
      ) u_chan (
        .clk           (clk),
        .reset         (reset),
        .pc_aligned    (pc_aligned),
        .ack           (ack),
        .cfg_load      (cfg_load),
        .cfg_target_pc (bus.cfg_target_pc),
        .cfg_count     (bus.cfg_count),
        .cfg_delay     (bus.cfg_delay),
        .interrupt     (interrupt[gi]),
        .timeout_flag  (timeout_flag[gi])
      );
    end
  endgenerate

  assign irq_any = |interrupt;

endmodule

// File: tb/tb_int_inject_ctrl.sv
// Self-checking bench for int_inject_ctrl: directed scenarios plus random traffic
// compared every cycle against an event-time reference model.
module tb_int_inject_ctrl;

  localparam int          NCH      = 4;
  localparam int          CH_W     = 2;
  localparam logic [31:0] ACK_BASE = 32'h0000_7f20;
  localparam int          TIMEOUT  = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] interrupt;
  logic           irq_any;
  logic [NCH-1:0] timeout_flag;

  int checks = 0;
  int failures = 0;

  int_inject_ctrl_if #(.NCH(NCH), .CNT_W(4), .DELAY_W(8)) bus ();

  int_inject_ctrl #(.NCH(NCH), .CNT_W(4), .DELAY_W(8), .ACK_BASE(ACK_BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .interrupt    (interrupt),
    .irq_any      (irq_any),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  // Reference model: each channel tracks when it fires (absolute edge index),
  // when it went high, and whether the PC must leave the target first.
  longint      edge_n = 0;
  logic [31:0] m_target [NCH];
  int          m_rem    [NCH];
  int          m_delay  [NCH];
  bit          m_irq    [NCH];
  longint      m_fire   [NCH];
  longint      m_aedge  [NCH];
  bit          m_wait   [NCH];
  bit          m_tflag  [NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_clear(input int k);
    m_target[k] = '0; m_rem[k] = 0; m_delay[k] = 0; m_irq[k] = 0;
    m_fire[k] = -1; m_aedge[k] = 0; m_wait[k] = 0; m_tflag[k] = 0;
  endtask

  task automatic model_release(input int k, input bit by_timeout);
    m_irq[k] = 0;
    m_rem[k] = (m_rem[k] > 0) ? m_rem[k] - 1 : 0;
    m_wait[k] = (m_rem[k] > 0);
    if (by_timeout) m_tflag[k] = 1;
  endtask

  task automatic model_update();
    bit mt, ak;
    edge_n++;
    for (int k = 0; k < NCH; k++) begin
      mt = ((bus.macroscopic_pc & 32'hffff_fffc) == m_target[k]);
      ak = (bus.m_int_byteen != 4'b0) &&
           ((bus.m_int_addr & 32'hffff_fffc) == ACK_BASE + 32'(4 * k));
      if (reset) begin
        model_clear(k);
      end else if (bus.cfg_we && int'(bus.cfg_ch) == k) begin
        model_clear(k);
        m_target[k] = bus.cfg_target_pc;
        m_rem[k]    = int'(bus.cfg_count);
        m_delay[k]  = int'(bus.cfg_delay);
      end else if (m_irq[k]) begin
        if (ak) model_release(k, 0);
`ifdef INT_TIMEOUT_EN
        else if (edge_n - m_aedge[k] >= TIMEOUT) model_release(k, 1);
`endif
      end else if (m_fire[k] >= 0) begin
        if (edge_n == m_fire[k]) begin
          m_irq[k] = 1; m_aedge[k] = edge_n; m_fire[k] = -1;
        end
      end else if (m_wait[k]) begin
        if (!mt) m_wait[k] = 0;
      end else if (m_rem[k] > 0 && mt) begin
        if (m_delay[k] == 0) begin
          m_irq[k] = 1; m_aedge[k] = edge_n;
        end else begin
          m_fire[k] = edge_n + m_delay[k];
        end
      end
    end
  endtask

  // Advance one clock with the currently driven inputs, then compare against the model.
  task automatic tick();
    logic [NCH-1:0] ei, et;
    model_update();
    @(posedge clk); #1;
    for (int k = 0; k < NCH; k++) begin
      ei[k] = m_irq[k];
      et[k] = m_tflag[k];
    end
    check("interrupt", 32'(interrupt), 32'(ei));
    check("irq_any", 32'(irq_any), 32'(|ei));
    check("timeout_flag", 32'(timeout_flag), 32'(et));
  endtask

  task automatic cfg(input int ch, input logic [31:0] tgt, input int cnt, input int dly);
    $display("cfg   ch=%0d target=%h count=%0d delay=%0d", ch, tgt, cnt, dly);
    bus.cfg_we = 1'b1; bus.cfg_ch = CH_W'(ch); bus.cfg_target_pc = tgt;
    bus.cfg_count = 4'(cnt); bus.cfg_delay = 8'(dly);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [3:0] be);
    bus.m_int_addr = addr; bus.m_int_byteen = be;
    tick();
    $display("store addr=%h be=%b -> interrupt=%b", addr, be, interrupt);
    bus.m_int_byteen = 4'b0;
  endtask

  task automatic pc_step(input logic [31:0] pc);
    bus.macroscopic_pc = pc;
    tick();
    $display("pc    %h -> interrupt=%b irq_any=%b", pc, interrupt, irq_any);
  endtask

  logic [31:0] pcs [4] = '{32'h3000, 32'h3004, 32'h3010, 32'h3020};

  initial begin
    bus.macroscopic_pc = '0; bus.m_int_addr = '0; bus.m_int_byteen = '0;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_target_pc = '0;
    bus.cfg_count = '0; bus.cfg_delay = '0;
    for (int k = 0; k < NCH; k++) model_clear(k);

    reset = 1'b1;
    tick(); tick();
    check("reset_interrupt", 32'(interrupt), 32'h0);
    check("reset_irq_any", 32'(irq_any), 32'h0);
    check("reset_timeout_flag", 32'(timeout_flag), 32'h0);
    reset = 1'b0;
    tick();

    // Single firing, zero delay
    cfg(0, 32'h3010, 1, 0);
    pc_step(32'h3010);
    check("t1_fire_same_edge", 32'(interrupt), 32'h1);
    bus.macroscopic_pc = 32'h3014;
    store(32'h7f20, 4'b0001);
    check("t1_ack_clears", 32'(interrupt), 32'h0);
    pc_step(32'h3010); pc_step(32'h3010);
    check("t1_no_refire", 32'(interrupt), 32'h0);

    // Delay 3 and ack address/byteen filtering
    cfg(1, 32'h3020, 1, 3);
    pc_step(32'h3020);
    check("t2_delay_edge0", 32'(interrupt), 32'h0);
    pc_step(32'h0); pc_step(32'h0);
    check("t2_delay_edge2", 32'(interrupt), 32'h0);
    pc_step(32'h0);
    check("t2_delay_edge3", 32'(interrupt), 32'h2);
    store(32'h7f20, 4'b1111);
    check("t2_wrong_addr", 32'(interrupt), 32'h2);
    store(32'h7f24, 4'b0000);
    check("t2_zero_byteen", 32'(interrupt), 32'h2);
    store(32'h7f24, 4'b1111);
    check("t2_ack_clears", 32'(interrupt), 32'h0);

    // Repeat count 2 with PC parked on the target across the ack
    bus.macroscopic_pc = 32'h0;
    cfg(0, 32'h3010, 2, 0);
    pc_step(32'h3010);
    check("t3_first_fire", 32'(interrupt), 32'h1);
    store(32'h7f20, 4'b0001);
    pc_step(32'h3010); pc_step(32'h3010);
    check("t3_held_no_refire", 32'(interrupt), 32'h0);
    pc_step(32'h0);
    pc_step(32'h3010);
    check("t3_second_fire", 32'(interrupt), 32'h1);
    bus.macroscopic_pc = 32'h0;
    store(32'h7f20, 4'b0001);
    pc_step(32'h0); pc_step(32'h3010);
    check("t3_third_visit", 32'(interrupt), 32'h0);

    // Two channels on the same target
    bus.macroscopic_pc = 32'h0;
    cfg(0, 32'h3000, 1, 0);
    cfg(2, 32'h3000, 1, 0);
    pc_step(32'h3000);
    check("t4_both_fire", 32'(interrupt), 32'h5);
    check("t4_irq_any", 32'(irq_any), 32'h1);
    bus.macroscopic_pc = 32'h0;
    store(32'h7f28, 4'b0100);
    check("t4_ack_ch2_only", 32'(interrupt), 32'h1);

    // Reset while ch0 asserted and ch1 in its delay window
    cfg(1, 32'h3040, 1, 5);
    pc_step(32'h3040);
    pc_step(32'h0);
    check("t5_pre_reset", 32'(interrupt), 32'h1);
    reset = 1'b1;
    tick();
    $display("reset -> interrupt=%b", interrupt);
    check("t5_reset_clears", 32'(interrupt), 32'h0);
    check("t5_reset_irq_any", 32'(irq_any), 32'h0);
    reset = 1'b0;
    pc_step(32'h3000); pc_step(32'h3040);
    for (int i = 0; i < 6; i++) tick();
    check("t5_config_lost", 32'(interrupt), 32'h0);

    // Long hold without ack: auto-release only when the timeout feature is built in
    bus.macroscopic_pc = 32'h0;
    cfg(0, 32'h3010, 1, 0);
    pc_step(32'h3010);
    bus.macroscopic_pc = 32'h0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("t6_hold_before_timeout", 32'(interrupt), 32'h1);
    tick();
`ifdef INT_TIMEOUT_EN
    check("t6_timeout_release", 32'(interrupt), 32'h0);
    check("t6_timeout_flag", 32'(timeout_flag), 32'h1);
    cfg(0, 32'h0, 0, 0);
    check("t6_cfg_clears_flag", 32'(timeout_flag), 32'h0);
`else
    check("t6_holds_forever", 32'(interrupt), 32'h1);
    check("t6_no_timeout_flag", 32'(timeout_flag), 32'h0);
    cfg(0, 32'h0, 0, 0);
    check("t6_cfg_drops_line", 32'(interrupt), 32'h0);
`endif

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 399) == 0);
      bus.cfg_we = ($urandom_range(0, 24) == 0);
      if (bus.cfg_we) begin
        bus.cfg_ch = CH_W'($urandom_range(0, NCH - 1));
        bus.cfg_target_pc = pcs[$urandom_range(0, 3)] | 32'($urandom_range(0, 9) == 0);
        bus.cfg_count = 4'($urandom_range(0, 3));
        bus.cfg_delay = 8'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 5));
        $display("rcfg  ch=%0d target=%h count=%0d delay=%0d", bus.cfg_ch,
                 bus.cfg_target_pc, bus.cfg_count, bus.cfg_delay);
      end
      if ($urandom_range(0, 1) == 0)
        bus.macroscopic_pc = pcs[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        bus.m_int_addr = ACK_BASE + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
        bus.m_int_byteen = ($urandom_range(0, 4) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      end else begin
        bus.m_int_byteen = 4'b0;
      end
      tick();
    end
    reset = 1'b0; bus.cfg_we = 1'b0; bus.m_int_byteen = 4'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
